// File: rtl/mnist_frame_feeder.sv
// Frame buffer plus AXI-Stream feeder and result collector for the FINN MNIST core.
// Ports: ap_clk/ap_rst, frame write port, start/busy/done/result/timeout, m_axis_0 pixel out, s_axis_0 class in.
module mnist_frame_feeder #(
  parameter int DATA_W      = 8,
  parameter int FRAME_LEN   = 784,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              timeout,
  output logic [DATA_W-1:0] m_axis_0_tdata,
  output logic              m_axis_0_tvalid,
  input  logic              m_axis_0_tready,
  input  logic [DATA_W-1:0] s_axis_0_tdata,
  input  logic              s_axis_0_tvalid,
  output logic              s_axis_0_tready
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int WC_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LEN   = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [WC_W-1:0]  WLAST = WC_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, WAIT_RES} state_t;

  state_t state;

  // Reset asserts at once, releases two clocks later.
  logic [1:0] rst_sr;
  logic       rst;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) rst_sr <= 2'b11;
    else        rst_sr <= {rst_sr[0], 1'b0};
  end

  assign rst = rst_sr[1];

  logic [DATA_W-1:0] mem [FRAME_LEN];
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] sk_data;
  logic              sk_valid;
  logic              rd_pend;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  beat;
  logic [WC_W-1:0]   wcnt;
  logic              wr_ok;
  logic              start_ok;
  logic              issue;
  logic              rd_en;
  logic              pop;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        occ;

  assign wr_ok    = wr_en && !busy && ({1'b0, wr_addr} < LEN);
  assign start_ok = (state == IDLE) && start && !done;
  assign pop      = m_axis_0_tvalid && m_axis_0_tready;

  // Slots held or in flight after this cycle's pop: output reg, skid reg, BRAM read.
  assign occ = {1'b0, m_axis_0_tvalid} + {1'b0, sk_valid}
             + {1'b0, rd_pend} - {1'b0, pop};

  assign issue = ((state == PRIME) || (state == STREAM))
              && (rd_cnt < LEN) && (occ < 2'd2);
  assign rd_en   = start_ok || issue;
  assign rd_addr = start_ok ? '0 : rd_cnt[ADDR_W-1:0];

  // Write-first so a write in the start cycle reaches byte 0.
  always_ff @(posedge ap_clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    if (rd_en) begin
      if (wr_ok && (wr_addr == rd_addr)) rd_data <= wr_data;
      else                               rd_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge ap_clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      timeout         <= 1'b0;
      result          <= '0;
      m_axis_0_tdata  <= '0;
      m_axis_0_tvalid <= 1'b0;
      s_axis_0_tready <= 1'b0;
      sk_data         <= '0;
      sk_valid        <= 1'b0;
      rd_pend         <= 1'b0;
      rd_cnt          <= '0;
      beat            <= '0;
      wcnt            <= '0;
    end else begin
      done    <= 1'b0;
      rd_pend <= rd_en;

      if (start_ok)   rd_cnt <= CNT_W'(1);
      else if (issue) rd_cnt <= rd_cnt + 1'b1;

      // Output reg is the oldest byte, skid reg the next one.
      if (!m_axis_0_tvalid || pop) begin
        if (sk_valid) begin
          m_axis_0_tdata  <= sk_data;
          m_axis_0_tvalid <= 1'b1;
          sk_data         <= rd_data;
          sk_valid        <= rd_pend;
        end else if (rd_pend) begin
          m_axis_0_tdata  <= rd_data;
          m_axis_0_tvalid <= 1'b1;
        end else begin
          m_axis_0_tvalid <= 1'b0;
        end
      end else if (rd_pend) begin
        sk_data  <= rd_data;
        sk_valid <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (start_ok) begin
            state   <= PRIME;
            busy    <= 1'b1;
            timeout <= 1'b0;
            beat    <= '0;
          end
        end
        PRIME: state <= STREAM;
        STREAM: begin
          if (pop) begin
            if (beat == LAST) begin
              state           <= WAIT_RES;
              s_axis_0_tready <= 1'b1;
              wcnt            <= '0;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        WAIT_RES: begin
          if (s_axis_0_tvalid) begin
            result          <= s_axis_0_tdata;
            done            <= 1'b1;
            busy            <= 1'b0;
            s_axis_0_tready <= 1'b0;
            state           <= IDLE;
          end else if (wcnt == WLAST) begin
            timeout         <= 1'b1;
            done            <= 1'b1;
            busy            <= 1'b0;
            s_axis_0_tready <= 1'b0;
            state           <= IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mnist_frame_feeder.sv
// Self-checking bench for mnist_frame_feeder.
// Table of run scenarios plus hand-written reset and load sequences.
module tb_mnist_frame_feeder;

  localparam int N = 784;

  logic       ap_clk = 1'b0;
  logic       ap_rst;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       timeout;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [N];

  always #5 ap_clk = ~ap_clk;

  mnist_frame_feeder #(
    .DATA_W(8), .FRAME_LEN(N), .ADDR_W(10), .TIMEOUT_CYC(16)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start(start),
    .busy(busy),
    .done(done),
    .result(result),
    .timeout(timeout),
    .m_axis_0_tdata(m_tdata),
    .m_axis_0_tvalid(m_tvalid),
    .m_axis_0_tready(m_tready),
    .s_axis_0_tdata(s_tdata),
    .s_axis_0_tvalid(s_tvalid),
    .s_axis_0_tready(s_tready)
  );

  typedef struct {
    logic [3:0] rdy;
    int         resp_at;
    logic [7:0] rdata;
    logic       exp_to;
    logic [7:0] exp_res;
    logic       inject;
    logic       wr0;
    logic [7:0] wdata0;
    int         rst_at;
  } vec_t;

  vec_t tbl [6];

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, busy, done, timeout, m_tvalid, s_tready, m_tdata, result};
  endfunction

  task automatic run(input vec_t v);
    int beats;
    int cyc;
    int w;
    int exp_w;
    logic prev_stall;
    logic [7:0] prev_data;
    logic rdy;
    logic seen;
    start = 1'b1;
    if (v.wr0) begin
      wr_en   = 1'b1;
      wr_addr = 10'd0;
      wr_data = v.wdata0;
      model[0] = v.wdata0;
    end
    step();
    start = 1'b0;
    wr_en = 1'b0;
    chk("prime_busy", busy, 1);
    chk("prime_timeout_clr", timeout, 0);
    chk("prime_tvalid", m_tvalid, 0);
    step();
    chk("first_valid_lat", m_tvalid, 1);
    beats = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    while (beats < N && cyc < 4000) begin
      if (v.rst_at >= 0 && beats == v.rst_at) begin
        ap_rst = 1'b1;
        #1;
        chk("rst_async_outs", outs(), 0);
        m_tready = 1'b0;
        repeat (2) step();
        ap_rst = 1'b0;
        repeat (4) step();
        chk("rst_release_outs", outs(), 0);
        return;
      end
      rdy = v.rdy[cyc % 4];
      m_tready = rdy;
      if (v.inject && cyc == 1) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 10'd3;
        wr_data = 8'hAA;
      end
      if (prev_stall) begin
        chk("stall_valid", m_tvalid, 1);
        chk("stall_data", m_tdata, prev_data);
      end
      if (m_tvalid && rdy) begin
        chk($sformatf("beat%0d", beats), m_tdata, model[beats]);
        beats++;
      end
      prev_stall = m_tvalid && !rdy;
      prev_data = m_tdata;
      step();
      start = 1'b0;
      wr_en = 1'b0;
      cyc++;
    end
    m_tready = 1'b0;
    chk("beat_count", beats, N);
    if (v.rdy == 4'b1111) chk("no_bubble_cycles", cyc, N);
    chk("tvalid_drop", m_tvalid, 0);
    chk("wait_entry", s_tready, 1);
    w = 0;
    while (!done && w < 100) begin
      s_tvalid = (w == v.resp_at);
      s_tdata = v.rdata;
      step();
      w++;
    end
    s_tvalid = 1'b0;
    exp_w = (v.resp_at < 0) ? 16 : v.resp_at + 1;
    chk("done_cycle", w, exp_w);
    chk("done", done, 1);
    chk("busy_at_done", busy, 0);
    chk("timeout", timeout, v.exp_to);
    chk("result", result, v.exp_res);
    chk("s_tready_off", s_tready, 0);
    if (v.inject) start = 1'b1;
    step();
    start = 1'b0;
    chk("done_pulse", done, 0);
    chk("busy_after", busy, 0);
    seen = 1'b0;
    repeat (6) begin
      seen = seen | m_tvalid | busy;
      step();
    end
    chk("single_run", seen, 0);
  endtask

  initial begin
    tbl[0] = '{4'b1111,  4, 8'h07, 1'b0, 8'h07, 1'b0, 1'b0, 8'h00,  -1};
    tbl[1] = '{4'b1001, -1, 8'h00, 1'b1, 8'h07, 1'b0, 1'b0, 8'h00,  -1};
    tbl[2] = '{4'b1111,  0, 8'h3C, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00,  -1};
    tbl[3] = '{4'b1111,  1, 8'h11, 1'b0, 8'h11, 1'b0, 1'b1, 8'h5A,  -1};
    tbl[4] = '{4'b1111,  0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 400};
    tbl[5] = '{4'b0110,  2, 8'h22, 1'b0, 8'h22, 1'b0, 1'b0, 8'h00,  -1};

    ap_rst   = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    start    = 1'b0;
    m_tready = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    repeat (3) step();
    chk("in_reset_outs", outs(), 0);
    ap_rst = 1'b0;
    repeat (4) step();
    chk("reset_outs", outs(), 0);

    for (int a = 0; a < N; a++) begin
      wr_en   = 1'b1;
      wr_addr = 10'(a);
      wr_data = 8'(a);
      model[a] = 8'(a);
      step();
    end
    wr_en = 1'b0;
    step();
    chk("idle_after_load", outs(), 0);

    for (int i = 0; i < 6; i++) run(tbl[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
